// File: rtl/mem_xfer_unit_if.sv
// Purpose: bundles the datapath-side and memory-side signals of mem_xfer_unit.
// Ports:   bus_in/MARin/MDRin/read/write and MAR/MDR/busy/done/err face the
//          datapath; mem_* face the RAM. slave = the unit, master = its environment.
interface mem_xfer_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) ();
   // datapath side
   logic [DATA_W-1:0] bus_in;
   logic              MARin;
   logic              MDRin;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] MAR;
   logic [DATA_W-1:0] MDR;
   logic              busy;
   logic              done;
   logic              err;
   // memory side
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  bus_in, MARin, MDRin, read, write, mem_rdata, mem_ack,
      output MAR, MDR, busy, done, err, mem_addr, mem_wdata, mem_rd, mem_wr
   );

   modport master (
      output bus_in, MARin, MDRin, read, write, mem_rdata, mem_ack,
      input  MAR, MDR, busy, done, err, mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/mem_xfer_unit.sv
// Purpose: owns MAR/MDR and sequences multi-cycle RAM reads/writes with timeout.
// Latency: done after the mem_ack edge (USE_ACK=1) or WAIT_CYCLES edges after start;
//          err after TIMEOUT ack-less edges or on a read+write collision.
// Backpressure: while busy, MARin/MDRin/read/write are ignored and MAR/MDR frozen.
// Ports: clk, clear (async active-high); bus = mem_xfer_unit_if.slave.
module mem_xfer_unit #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter bit USE_ACK     = 1'b1,
   parameter int WAIT_CYCLES = 2,
   parameter int TIMEOUT     = 15
) (
   input  logic             clk,
   input  logic             clear,
   mem_xfer_unit_if.slave   bus
);
   localparam int MAX_CNT = (TIMEOUT > WAIT_CYCLES) ? TIMEOUT : WAIT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   // cnt holds (edges spent in RD/WR) - 1, so the final edge is seen at N-1
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] mar_q;
   logic [DATA_W-1:0] mdr_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              rd_q;
   logic              wr_q;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state  <= IDLE;
         cnt    <= '0;
         mar_q  <= '0;
         mdr_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (bus.MARin) mar_q <= bus.bus_in[ADDR_W-1:0];
               if (bus.MDRin) mdr_q <= bus.bus_in;
               if (bus.read && bus.write) begin
                  // ambiguous request: reject it rather than guess a direction
                  err_q <= 1'b1;
               end else if (bus.read) begin
                  state  <= RD;
                  rd_q   <= 1'b1;
                  busy_q <= 1'b1;
               end else if (bus.write) begin
                  state  <= WR;
                  wr_q   <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            RD, WR: begin
               // ack is tested before the timeout so an ack on the last edge wins
               if ((USE_ACK && bus.mem_ack) || (!USE_ACK && cnt == WAIT_LAST)) begin
                  if (state == RD) mdr_q <= bus.mem_rdata;
                  done_q <= 1'b1;
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  rd_q   <= 1'b0;
                  wr_q   <= 1'b0;
               end else if (USE_ACK && cnt == TO_LAST) begin
                  err_q  <= 1'b1;
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  rd_q   <= 1'b0;
                  wr_q   <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               rd_q   <= 1'b0;
               wr_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.MAR       = mar_q;
   assign bus.MDR       = mdr_q;
   assign bus.mem_addr  = mar_q;
   assign bus.mem_wdata = mdr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.mem_rd    = rd_q;
   assign bus.mem_wr    = wr_q;
endmodule

// File: tb/tb_mem_xfer_unit.sv
// Purpose: directed self-checking bench for mem_xfer_unit (ack mode and fixed latency).
// Latency: inputs change 1ns after a rising edge; outputs sampled at the same point.
// Backpressure: exercised by loading MDR while a write is in flight.
module tb_mem_xfer_unit;
   logic clk;
   logic clear;
   int   n_cmp;
   int   n_bad;

   mem_xfer_unit_if #(.DATA_W(32), .ADDR_W(9)) ia ();
   mem_xfer_unit_if #(.DATA_W(32), .ADDR_W(9)) fx ();

   mem_xfer_unit #(
      .DATA_W(32), .ADDR_W(9), .USE_ACK(1'b1), .WAIT_CYCLES(2), .TIMEOUT(15)
   ) u_ack (
      .clk   (clk),
      .clear (clear),
      .bus   (ia.slave)
   );

   mem_xfer_unit #(
      .DATA_W(32), .ADDR_W(9), .USE_ACK(1'b0), .WAIT_CYCLES(2), .TIMEOUT(15)
   ) u_fix (
      .clk   (clk),
      .clear (clear),
      .bus   (fx.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      clear = 1'b1;
      ia.bus_in = '0; ia.MARin = 0; ia.MDRin = 0; ia.read = 0; ia.write = 0;
      ia.mem_rdata = '0; ia.mem_ack = 0;
      fx.bus_in = '0; fx.MARin = 0; fx.MDRin = 0; fx.read = 0; fx.write = 0;
      fx.mem_rdata = '0; fx.mem_ack = 0;

      // reset state
      #12;
      check("rst_mar",  ia.MAR, 0);
      check("rst_mdr",  ia.MDR, 0);
      check("rst_busy", ia.busy, 0);
      check("rst_flags", {ia.done, ia.err, ia.mem_rd, ia.mem_wr}, 0);
      clear = 1'b0;
      tick();

      // read at 0x123, ack on the 3rd edge
      ia.bus_in = 32'h0000_0123; ia.MARin = 1;
      tick();
      ia.MARin = 0; ia.bus_in = '0;
      check("a_mar", ia.MAR, 9'h123);
      ia.read = 1;
      tick();                                   // edge k
      ia.read = 0; ia.mem_rdata = 32'hDEAD_BEEF;
      check("a_busy1", {ia.busy, ia.mem_rd, ia.mem_addr}, {2'b11, 9'h123});
      tick();                                   // k+1
      check("a_busy2", {ia.busy, ia.done, ia.mem_addr}, {2'b10, 9'h123});
      tick();                                   // k+2
      check("a_busy3", {ia.busy, ia.done, ia.mem_addr}, {2'b10, 9'h123});
      ia.mem_ack = 1;
      tick();                                   // k+3 ack
      ia.mem_ack = 0;
      check("a_done", {ia.done, ia.busy, ia.mem_rd, ia.err}, 4'b1000);
      check("a_mdr", ia.MDR, 32'hDEAD_BEEF);
      tick();
      check("a_done_pulse", ia.done, 0);

      // write with an MDRin attempt while busy
      ia.bus_in = 32'h1234_5678; ia.MDRin = 1;
      tick();
      ia.MDRin = 0; ia.write = 1;
      tick();
      ia.write = 0;
      check("w_start", {ia.busy, ia.mem_wr, ia.mem_rd}, 3'b110);
      ia.bus_in = 32'hFFFF_FFFF; ia.MDRin = 1;
      tick();
      ia.MDRin = 0;
      check("w_wdata_frozen", ia.mem_wdata, 32'h1234_5678);
      check("w_mdr_frozen", ia.MDR, 32'h1234_5678);
      ia.mem_rdata = 32'h0BAD_0BAD; ia.mem_ack = 1;
      tick();
      ia.mem_ack = 0;
      check("w_done", {ia.done, ia.busy, ia.mem_wr}, 3'b100);
      check("w_mdr_kept", ia.MDR, 32'h1234_5678);
      tick();

      // read timeout: no ack for 15 edges
      ia.read = 1;
      tick();
      ia.read = 0; ia.mem_rdata = 32'h5555_5555;
      for (int i = 0; i < 14; i++) tick();      // edges k+1..k+14
      check("to_pre", {ia.busy, ia.err, ia.mem_rd}, 3'b101);
      tick();                                   // k+15
      check("to_err", {ia.err, ia.done, ia.busy, ia.mem_rd}, 4'b1000);
      check("to_mdr", ia.MDR, 32'h1234_5678);
      tick();
      check("to_err_pulse", ia.err, 0);

      // ack on the 15th edge beats the timeout
      ia.read = 1;
      tick();
      ia.read = 0;
      for (int i = 0; i < 14; i++) tick();
      ia.mem_ack = 1;
      tick();
      ia.mem_ack = 0;
      check("to_ack_wins", {ia.done, ia.err, ia.busy}, 3'b100);
      check("to_ack_mdr", ia.MDR, 32'h5555_5555);
      tick();

      // read and write together
      ia.read = 1; ia.write = 1;
      tick();
      ia.read = 0; ia.write = 0;
      check("rw_err", {ia.err, ia.busy, ia.mem_rd, ia.mem_wr, ia.done}, 5'b10000);
      tick();
      check("rw_idle", {ia.err, ia.busy}, 2'b00);

      // fixed latency, back-to-back reads
      fx.bus_in = 32'h0000_00AA; fx.MARin = 1;
      tick();
      fx.MARin = 0; fx.read = 1; fx.mem_rdata = 32'hA5A5_A5A5;
      tick();                                   // edge k
      fx.read = 0;
      check("f_busy", {fx.busy, fx.mem_rd, fx.mem_addr}, {2'b11, 9'h0AA});
      tick();                                   // k+1
      check("f_wait", {fx.done, fx.busy}, 2'b01);
      tick();                                   // k+2
      check("f_done", {fx.done, fx.busy, fx.mem_rd}, 3'b100);
      check("f_mdr", fx.MDR, 32'hA5A5_A5A5);
      fx.read = 1; fx.mem_rdata = 32'h3C3C_3C3C;
      tick();
      fx.read = 0;
      check("f_b2b_start", {fx.busy, fx.mem_rd, fx.done}, 3'b110);
      tick();
      tick();
      check("f_b2b_done", {fx.done, fx.busy}, 2'b10);
      check("f_b2b_mdr", fx.MDR, 32'h3C3C_3C3C);
      tick();

      // clear in the middle of a read
      ia.bus_in = 32'h0000_0077; ia.MARin = 1; ia.read = 1;
      tick();
      ia.MARin = 0; ia.read = 0;
      check("cl_pre", {ia.mem_rd, ia.busy}, 2'b11);
      #2 clear = 1'b1;
      #1;
      check("cl_async", {ia.busy, ia.mem_rd, ia.mem_wr, ia.done, ia.err}, 0);
      check("cl_regs", {ia.MAR, ia.MDR, ia.mem_addr, ia.mem_wdata}, 0);
      #3 clear = 1'b0;
      ia.mem_ack = 1;
      tick();
      check("cl_after1", {ia.busy, ia.done, ia.err, ia.mem_rd}, 0);
      tick();
      ia.mem_ack = 0;
      check("cl_after2", {ia.busy, ia.done, ia.err, ia.MDR}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
